// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: single-outstanding vector instruction issue sequencer
// Ports: clk/rst (async high); instr_valid/instr_ready/instr/unit_sel/wr_dest accept side;
// instr_q/is_mul_q latched instruction; start_* unit start pulses; done_* unit completions;
// vconfig_wr_en/v_reg_wr_en/x_reg_wr_en write pulses; busy; err/err_code/err_clr; retired_cnt.
module v_issue_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [2:0]  unit_sel,
  input  logic [1:0]  wr_dest,
  output logic [31:0] instr_q,
  output logic        is_mul_q,
  output logic        start_vlanes,
  output logic        start_vred,
  output logic        start_vsldu,
  output logic        start_vlsu,
  input  logic        done_vlanes,
  input  logic        done_vred,
  input  logic        done_vsldu,
  input  logic        done_vlsu,
  output logic        vconfig_wr_en,
  output logic        v_reg_wr_en,
  output logic        x_reg_wr_en,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        err_clr,
  output logic [15:0] retired_cnt
);
  typedef enum logic [2:0] {IDLE, VCFG, ISSUE, WAIT, WB} state_t;
  state_t state, state_d;
  logic [2:0] unit_q;
  logic [1:0] wr_q;
  logic [CNT_W-1:0] timer;
  logic done_sel, timeout, illegal, to_err, accept;
  always_comb begin
    accept = state == IDLE && instr_valid;
    illegal = accept && unit_sel > 3'd5;
    done_sel = (unit_q == 3'd1 || unit_q == 3'd2) ? done_vlanes :
               unit_q == 3'd3 ? done_vred :
               unit_q == 3'd4 ? done_vsldu :
               unit_q == 3'd5 ? done_vlsu : 1'b0;
    timeout = timer == CNT_W'(TIMEOUT_CYC - 1);
    // done has priority over a timeout expiring in the same cycle
    to_err = state == WAIT && !done_sel && timeout;
    state_d = state;
    case (state)
      IDLE:    state_d = !accept ? IDLE : unit_sel == 3'd0 ? VCFG : illegal ? IDLE : ISSUE;
      VCFG:    state_d = IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = done_sel ? WB : timeout ? IDLE : WAIT;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      instr_q <= '0;
      unit_q <= '0;
      wr_q <= '0;
      timer <= '0;
      err <= 1'b0;
      err_code <= 2'd0;
      retired_cnt <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        instr_q <= instr;
        unit_q <= unit_sel;
        wr_q <= wr_dest;
      end
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (illegal || to_err) begin
        err <= 1'b1;
        err_code <= illegal ? 2'd2 : 2'd1;
      end else if (err_clr) begin
        err <= 1'b0;
        err_code <= 2'd0;
      end
      if (state == VCFG || state == WB) retired_cnt <= retired_cnt + 1'b1;
    end
  end
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign is_mul_q = unit_q == 3'd2;
  assign start_vlanes = state == ISSUE && (unit_q == 3'd1 || unit_q == 3'd2);
  assign start_vred = state == ISSUE && unit_q == 3'd3;
  assign start_vsldu = state == ISSUE && unit_q == 3'd4;
  assign start_vlsu = state == ISSUE && unit_q == 3'd5;
  assign vconfig_wr_en = state == VCFG;
  assign v_reg_wr_en = state == WB && wr_q == 2'd1;
  assign x_reg_wr_en = state == WB && wr_q == 2'd2;
endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb_v_issue_ctrl: directed self-checking bench for v_issue_ctrl
module tb_v_issue_ctrl;
  logic clk = 0, rst = 1, instr_valid = 0, err_clr = 0;
  logic done_vlanes = 0, done_vred = 0, done_vsldu = 0, done_vlsu = 0;
  logic [31:0] instr = 0;
  logic [2:0] unit_sel = 0;
  logic [1:0] wr_dest = 0;
  logic instr_ready, is_mul_q, start_vlanes, start_vred, start_vsldu, start_vlsu;
  logic vconfig_wr_en, v_reg_wr_en, x_reg_wr_en, busy, err;
  logic [31:0] instr_q;
  logic [1:0] err_code;
  logic [15:0] retired_cnt;
  int checks = 0, passes = 0, n_start = 0, n_wr = 0;
  v_issue_ctrl #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .unit_sel(unit_sel), .wr_dest(wr_dest), .instr_q(instr_q), .is_mul_q(is_mul_q),
    .start_vlanes(start_vlanes), .start_vred(start_vred), .start_vsldu(start_vsldu), .start_vlsu(start_vlsu),
    .done_vlanes(done_vlanes), .done_vred(done_vred), .done_vsldu(done_vsldu), .done_vlsu(done_vlsu),
    .vconfig_wr_en(vconfig_wr_en), .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en),
    .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr), .retired_cnt(retired_cnt));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (start_vlanes | start_vred | start_vsldu | start_vlsu) n_start <= n_start + 1;
    if (v_reg_wr_en | x_reg_wr_en) n_wr <= n_wr + 1;
  end
  task automatic offer(input logic [2:0] u, input logic [1:0] w, input logic [31:0] i);
    instr_valid = 1; unit_sel = u; wr_dest = w; instr = i;
    @(negedge clk);
    instr_valid = 0;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready got ready=%b busy=%b exp 1 0", instr_ready, busy); else passes++;
    checks++; if ({err, err_code, retired_cnt, instr_q} !== '0) $display("FAIL reset_regs got err=%b code=%0d cnt=%0d iq=%h exp zeros", err, err_code, retired_cnt, instr_q); else passes++;
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask
  task automatic test_lanes;
    int s_st, s_wr;
    s_st = n_start; s_wr = n_wr;
    checks++; if (instr_ready !== 1'b1) $display("FAIL lanes_ready0 got %b exp 1", instr_ready); else passes++;
    offer(3'd1, 2'd1, 32'h1234_5678);
    checks++; if (start_vlanes !== 1'b1 || busy !== 1'b1 || instr_q !== 32'h1234_5678) $display("FAIL lanes_start got st=%b busy=%b iq=%h exp 1 1 12345678", start_vlanes, busy, instr_q); else passes++;
    done_vlanes = 1;
    @(negedge clk);
    checks++; if (start_vlanes !== 1'b0 || v_reg_wr_en !== 1'b0) $display("FAIL lanes_wait got st=%b vwr=%b exp 0 0", start_vlanes, v_reg_wr_en); else passes++;
    @(negedge clk);
    checks++; if (v_reg_wr_en !== 1'b1 || x_reg_wr_en !== 1'b0) $display("FAIL lanes_wb got v=%b x=%b exp 1 0", v_reg_wr_en, x_reg_wr_en); else passes++;
    done_vlanes = 0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1 || retired_cnt !== 16'd1) $display("FAIL lanes_end got ready=%b cnt=%0d exp 1 1", instr_ready, retired_cnt); else passes++;
    checks++; if (n_start - s_st !== 1 || n_wr - s_wr !== 1) $display("FAIL lanes_pulses got starts=%0d writes=%0d exp 1 1", n_start - s_st, n_wr - s_wr); else passes++;
  endtask
  task automatic test_reset_mid_wait;
    int s_wr;
    offer(3'd2, 2'd1, 32'hCAFE_0001);
    checks++; if (is_mul_q !== 1'b1) $display("FAIL mul_flag got %b exp 1", is_mul_q); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rstw_busy got %b exp 1", busy); else passes++;
    #2 rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || instr_ready !== 1'b1 || retired_cnt !== 16'd0) $display("FAIL rstw_state got busy=%b ready=%b cnt=%0d exp 0 1 0", busy, instr_ready, retired_cnt); else passes++;
    checks++; if ({instr_q, is_mul_q, start_vlanes, v_reg_wr_en} !== '0) $display("FAIL rstw_regs got iq=%h mul=%b st=%b v=%b exp zeros", instr_q, is_mul_q, start_vlanes, v_reg_wr_en); else passes++;
    done_vlanes = 1;
    @(negedge clk); rst = 0;
    s_wr = n_wr;
    repeat (5) @(negedge clk);
    checks++; if (n_wr !== s_wr || retired_cnt !== 16'd0) $display("FAIL rstw_after got writes=%0d cnt=%0d exp 0 0", n_wr - s_wr, retired_cnt); else passes++;
    done_vlanes = 0;
  endtask
  task automatic test_unit_select;
    done_vsldu = 1;
    offer(3'd3, 2'd2, 32'h0000_0333);
    checks++; if (start_vred !== 1'b1 || start_vsldu !== 1'b0) $display("FAIL red_start got red=%b sldu=%b exp 1 0", start_vred, start_vsldu); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || x_reg_wr_en !== 1'b0) $display("FAIL red_wait%0d got busy=%b x=%b exp 1 0", i, busy, x_reg_wr_en); else passes++;
    end
    done_vred = 1;
    @(negedge clk);
    checks++; if (x_reg_wr_en !== 1'b1 || v_reg_wr_en !== 1'b0) $display("FAIL red_wb got x=%b v=%b exp 1 0", x_reg_wr_en, v_reg_wr_en); else passes++;
    done_vred = 0; done_vsldu = 0;
    @(negedge clk);
    checks++; if (retired_cnt !== 16'd1 || instr_ready !== 1'b1) $display("FAIL red_end got cnt=%0d ready=%b exp 1 1", retired_cnt, instr_ready); else passes++;
  endtask
  task automatic test_timeout;
    int s_wr;
    s_wr = n_wr;
    offer(3'd4, 2'd1, 32'h0000_0444);
    checks++; if (start_vsldu !== 1'b1) $display("FAIL to_start got %b exp 1", start_vsldu); else passes++;
    repeat (64) @(negedge clk);
    checks++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL to_last_wait got busy=%b err=%b exp 1 0", busy, err); else passes++;
    @(negedge clk);
    checks++; if (err !== 1'b1 || err_code !== 2'd1 || instr_ready !== 1'b1) $display("FAIL to_err got err=%b code=%0d ready=%b exp 1 1 1", err, err_code, instr_ready); else passes++;
    checks++; if (n_wr !== s_wr || retired_cnt !== 16'd1) $display("FAIL to_nowrite got writes=%0d cnt=%0d exp 0 1", n_wr - s_wr, retired_cnt); else passes++;
  endtask
  task automatic test_illegal;
    int s_st;
    s_st = n_start;
    offer(3'd7, 2'd1, 32'h0000_0777);
    checks++; if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) $display("FAIL ill_err got err=%b code=%0d busy=%b exp 1 2 0", err, err_code, busy); else passes++;
    @(negedge clk);
    checks++; if (n_start !== s_st || retired_cnt !== 16'd1) $display("FAIL ill_noissue got starts=%0d cnt=%0d exp 0 1", n_start - s_st, retired_cnt); else passes++;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    checks++; if (err !== 1'b0 || err_code !== 2'd0) $display("FAIL ill_clr got err=%b code=%0d exp 0 0", err, err_code); else passes++;
    err_clr = 1;
    offer(3'd6, 2'd0, 32'h0000_0666);
    err_clr = 0;
    checks++; if (err !== 1'b1 || err_code !== 2'd2) $display("FAIL ill_clr_race got err=%b code=%0d exp 1 2", err, err_code); else passes++;
  endtask
  task automatic test_vcfg_wrap;
    force dut.retired_cnt = 16'hFFFF;
    #1 release dut.retired_cnt;
    @(negedge clk);
    checks++; if (retired_cnt !== 16'hFFFF) $display("FAIL wrap_preset got %h exp ffff", retired_cnt); else passes++;
    offer(3'd0, 2'd1, 32'h0000_0000);
    checks++; if (vconfig_wr_en !== 1'b1 || v_reg_wr_en !== 1'b0 || busy !== 1'b1) $display("FAIL vcfg_pulse got cfg=%b v=%b busy=%b exp 1 0 1", vconfig_wr_en, v_reg_wr_en, busy); else passes++;
    @(negedge clk);
    checks++; if (vconfig_wr_en !== 1'b0 || retired_cnt !== 16'd0 || instr_ready !== 1'b1) $display("FAIL vcfg_wrap got cfg=%b cnt=%h ready=%b exp 0 0000 1", vconfig_wr_en, retired_cnt, instr_ready); else passes++;
  endtask
  initial begin
    test_reset;
    test_lanes;
    test_reset_mid_wait;
    test_unit_select;
    test_timeout;
    test_illegal;
    test_vcfg_wrap;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
